fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Fetch-stage PC generator. It drives the instruction-memory address and produces the PC+1 value and bubble control that feed the F/D pipeline latch. It owns the PC register, resolves redirects from decode (jump) and execute (taken branch), honours load-use stalls, and freezes on halt. It also keeps a fetch performance counter.

Parameters:
PC_WIDTH, 12, width of PC and instruction-memory address
RESET_PC, 12'd0, PC value loaded on reset
BOOT_CYCLES, 1, idle cycles after reset release before the first valid fetch (range 1..3)

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-low; 0 = reset asserted
hazard  in  1  load-use stall from hazard unit; hold PC
jump_d  in  1  decode-stage jump/jal/jr resolved
jump_target  in  PC_WIDTH  jump destination
branch_taken  in  1  execute-stage branch resolved taken
branch_target  in  PC_WIDTH  branch destination
halt  in  1  halt instruction reached writeback
address_imem  out  PC_WIDTH  instruction-memory address (= current PC)
next_pc_f  out  PC_WIDTH  PC+1, forwarded to F/D latch
flush_fd  out  1  insert bubble into F/D latch this cycle
fetch_valid  out  1  current address_imem is a real fetch
halted  out  1  unit is in HALTED state
fetch_count  out  32  number of accepted fetches since reset

Behaviour:
- State machine: BOOT, RUN, HALTED. Reset forces BOOT.
- BOOT: a down-counter is loaded with BOOT_CYCLES. PC is held at RESET_PC, fetch_valid=0, flush_fd=1. When the counter reaches 0, go to RUN.
- RUN: fetch_valid=1. PC update priority, highest first:
  - halt: go to HALTED, PC held.
  - branch_taken: PC <= branch_target, flush_fd=1.
  - jump_d: PC <= jump_target, flush_fd=1.
  - hazard: PC held, flush_fd=0. The latch handles its own bubble.
  - otherwise: PC <= PC+1.
- HALTED: PC held, fetch_valid=0, flush_fd=1, halted=1. Only reset exits this state.
- address_imem is the PC register output directly. It changes only on a clock edge, never combinationally from inputs.
- next_pc_f = PC+1, combinational, modulo 2^PC_WIDTH. 12'hFFF+1 wraps to 12'h000 with no flag.
- flush_fd is combinational from the current state and inputs. It is asserted in the same cycle as the redirect so the wrong-path word in the latch input is squashed.
- Simultaneous events:
  - branch_taken with jump_d: branch wins (older instruction); the jump is discarded.
  - branch_taken or jump_d with hazard: the redirect wins and the stall is ignored for the PC.
  - halt with any other input: halt wins.
- fetch_count:
  - Increments by 1 on each RUN-state edge where no halt, branch_taken, jump_d or hazard is present (i.e., the PC advanced sequentially).
  - Redirect cycles do not count.
  - Saturates at 32'hFFFF_FFFF.
- Reset values while reset=0: PC=RESET_PC, state=BOOT, counter=BOOT_CYCLES, fetch_count=0, fetch_valid=0, flush_fd=1, halted=0, address_imem=RESET_PC, next_pc_f=RESET_PC+1.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock. After release, the BOOT sequence repeats in full.
- Unknown or unused state encodings recover to BOOT on the next edge.

Test Plan:
1. Reset low for 3 cycles, then release (BOOT_CYCLES=1) -> one cycle with fetch_valid=0, flush_fd=1, address_imem=0. Then address_imem runs 0,1,2,3 on successive edges, with next_pc_f one ahead each cycle.
2. In RUN at PC=5, pulse hazard for 2 cycles -> address_imem stays 5 for 2 extra cycles with flush_fd=0, then resumes 6. fetch_count does not increment during the stall.
3. PC=8, jump_d=1 with jump_target=12'h040 -> flush_fd=1 in that cycle; next address_imem=12'h040.
4. Same cycle: branch_taken=1 (target 12'h100), jump_d=1 (target 12'h040), hazard=1 -> address_imem=12'h100, flush_fd=1.
5. PC=12'hFFF with no stall or redirect -> next_pc_f=12'h000; next address_imem=12'h000.
6. Assert halt at PC=20 -> halted=1, fetch_valid=0, address_imem frozen at 20 for 10 cycles despite branch_taken pulses. Asynchronous reset pulse mid-cycle -> immediate return to RESET_PC, fetch_count=0, BOOT repeated.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: owns the PC, resolves redirects,
// honours load-use stalls, freezes on halt, counts fetches.
module fetch_pc_unit #(
  parameter int                  PC_WIDTH    = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  BOOT_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hazard,
  input  logic                jump_d,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] address_imem,
  output logic [PC_WIDTH-1:0] next_pc_f,
  output logic                flush_fd,
  output logic                fetch_valid,
  output logic                halted,
  output logic [31:0]         fetch_count
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [1:0] BOOT_INIT = 2'(BOOT_CYCLES);

  logic [1:0]          r_state;
  logic [1:0]          r_boot_cnt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_fetch_count;

  logic                w_run;
  logic                w_seq;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_pc_nxt;

  assign w_run    = (r_state == S_RUN);
  assign w_seq    = w_run & ~halt & ~branch_taken
                  & ~jump_d & ~hazard;
  assign w_pc_inc = r_pc + PC_WIDTH'(1);

  // Older instruction (branch) beats jump; any redirect beats stall.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_run && !halt) begin
      if (branch_taken)
        w_pc_nxt = branch_target;
      else if (jump_d)
        w_pc_nxt = jump_target;
      else if (!hazard)
        w_pc_nxt = w_pc_inc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_BOOT;
      r_boot_cnt    <= BOOT_INIT;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_seq && r_fetch_count != 32'hFFFF_FFFF)
        r_fetch_count <= r_fetch_count + 32'd1;
      case (r_state)
        S_BOOT: begin
          if (r_boot_cnt != 2'd0)
            r_boot_cnt <= r_boot_cnt - 2'd1;
          if (r_boot_cnt <= 2'd1)
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (halt)
            r_state <= S_HALT;
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_state    <= S_BOOT;
          r_boot_cnt <= BOOT_INIT;
          r_pc       <= RESET_PC;
        end
      endcase
    end
  end

  assign address_imem = r_pc;
  assign next_pc_f    = w_pc_inc;
  assign fetch_valid  = w_run;
  assign halted       = (r_state == S_HALT);
  assign flush_fd     = w_run ? (halt | branch_taken | jump_d)
                              : 1'b1;
  assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed plan scenarios plus random
// stimulus against a behavioural PC/mode model.
module tb_fetch_pc_unit;

  localparam int BOOT = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hazard = 1'b0;
  logic        jump_d = 1'b0;
  logic [11:0] jump_target = '0;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_target = '0;
  logic        halt = 1'b0;
  logic [11:0] address_imem;
  logic [11:0] next_pc_f;
  logic        flush_fd;
  logic        fetch_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  // model: mode 0=boot 1=run 2=halted
  int          m_mode;
  int          m_boot;
  logic [11:0] m_pc;
  logic [31:0] m_cnt;

  fetch_pc_unit #(
    .PC_WIDTH(12), .RESET_PC(12'd0), .BOOT_CYCLES(BOOT)
  ) dut (
    .clock(clock), .reset(reset), .hazard(hazard),
    .jump_d(jump_d), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .address_imem(address_imem),
    .next_pc_f(next_pc_f), .flush_fd(flush_fd),
    .fetch_valid(fetch_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_mode = 0;
    m_boot = BOOT;
    m_pc   = 12'd0;
    m_cnt  = 32'd0;
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      m_boot = m_boot - 1;
      if (m_boot == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (halt) m_mode = 2;
      else if (branch_taken) m_pc = branch_target;
      else if (jump_d) m_pc = jump_target;
      else if (!hazard) begin
        m_pc = 12'((int'(m_pc) + 1) % 4096);
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic drive(input logic h, input logic j,
                       input logic [11:0] jt, input logic b,
                       input logic [11:0] bt, input logic hl);
    hazard = h; jump_d = j; jump_target = jt;
    branch_taken = b; branch_target = bt; halt = hl;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    model_reset();
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (address_imem !== 12'd0 || fetch_valid !== 1'b0 ||
          flush_fd !== 1'b1 || halted !== 1'b0 ||
          next_pc_f !== 12'd1 || fetch_count !== 32'd0) begin
        failures++;
        $display("FAIL reset_hold addr=%h v=%b f=%b h=%b n=%h c=%0d",
                 address_imem, fetch_valid, flush_fd, halted,
                 next_pc_f, fetch_count);
      end
      tick();
    end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_boot_run();
    checks++;
    if (fetch_valid !== 1'b0 || flush_fd !== 1'b1 ||
        address_imem !== 12'd0) begin
      failures++;
      $display("FAIL boot_cycle v=%b f=%b addr=%h exp v=0 f=1 addr=0",
               fetch_valid, flush_fd, address_imem);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (address_imem !== 12'(i) || next_pc_f !== 12'(i + 1) ||
          fetch_valid !== 1'b1 || flush_fd !== 1'b0) begin
        failures++;
        $display("FAIL run_seq addr=%h next=%h v=%b f=%b exp addr=%h",
                 address_imem, next_pc_f, fetch_valid, flush_fd,
                 12'(i));
      end
      tick();
    end
    tick();
  endtask

  task automatic test_hazard();
    checks++;
    if (address_imem !== 12'd5 || fetch_count !== 32'd5) begin
      failures++;
      $display("FAIL pre_stall addr=%h cnt=%0d exp 005/5",
               address_imem, fetch_count);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if (address_imem !== 12'd5 || flush_fd !== 1'b0 ||
          fetch_count !== 32'd5) begin
        failures++;
        $display("FAIL stall addr=%h f=%b cnt=%0d exp 005/0/5",
                 address_imem, flush_fd, fetch_count);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (address_imem !== 12'd5 || fetch_count !== 32'd5) begin
      failures++;
      $display("FAIL post_stall addr=%h cnt=%0d exp 005/5",
               address_imem, fetch_count);
    end
    tick();
    checks++;
    if (address_imem !== 12'd6) begin
      failures++;
      $display("FAIL resume addr=%h exp 006", address_imem);
    end
  endtask

  task automatic test_jump();
    tick();
    tick();
    drive(0, 1, 12'h040, 0, 0, 0);
    checks++;
    if (address_imem !== 12'd8 || flush_fd !== 1'b1) begin
      failures++;
      $display("FAIL jump_flush addr=%h f=%b exp 008/1",
               address_imem, flush_fd);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (address_imem !== 12'h040 || fetch_count !== 32'd8) begin
      failures++;
      $display("FAIL jump_target addr=%h cnt=%0d exp 040/8",
               address_imem, fetch_count);
    end
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 12'h040, 1, 12'h100, 0);
    checks++;
    if (flush_fd !== 1'b1) begin
      failures++;
      $display("FAIL simul_flush f=%b exp 1", flush_fd);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (address_imem !== 12'h100 || fetch_count !== 32'd8) begin
      failures++;
      $display("FAIL simul_target addr=%h cnt=%0d exp 100/8",
               address_imem, fetch_count);
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 12'hFFF, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (address_imem !== 12'hFFF || next_pc_f !== 12'h000) begin
      failures++;
      $display("FAIL wrap_next addr=%h next=%h exp FFF/000",
               address_imem, next_pc_f);
    end
    tick();
    checks++;
    if (address_imem !== 12'h000 || fetch_count !== 32'd9) begin
      failures++;
      $display("FAIL wrap_addr addr=%h cnt=%0d exp 000/9",
               address_imem, fetch_count);
    end
  endtask

  task automatic test_halt_reset();
    drive(0, 1, 12'd20, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1'(i % 2), 12'($urandom), 0);
      checks++;
      if (halted !== 1'b1 || fetch_valid !== 1'b0 ||
          address_imem !== 12'd20 || flush_fd !== 1'b1) begin
        failures++;
        $display("FAIL halted h=%b v=%b addr=%h f=%b exp 1/0/014/1",
                 halted, fetch_valid, address_imem, flush_fd);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (address_imem !== 12'd0 || fetch_count !== 32'd0 ||
        halted !== 1'b0 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset addr=%h cnt=%0d h=%b v=%b",
               address_imem, fetch_count, halted, fetch_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || flush_fd !== 1'b1 ||
        address_imem !== 12'd0) begin
      failures++;
      $display("FAIL reboot v=%b f=%b addr=%h exp 0/1/000",
               fetch_valid, flush_fd, address_imem);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || address_imem !== 12'd0) begin
      failures++;
      $display("FAIL reboot_run v=%b addr=%h exp 1/000",
               fetch_valid, address_imem);
    end
    tick();
    checks++;
    if (address_imem !== 12'd1 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL reboot_seq addr=%h cnt=%0d exp 001/1",
               address_imem, fetch_count);
    end
  endtask

  task automatic test_random();
    logic exp_flush;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 6) == 0,
            12'($urandom), ($urandom % 6) == 0, 12'($urandom),
            ($urandom % 300) == 0);
      exp_flush = (m_mode != 1) || branch_taken || jump_d;
      checks++;
      if (address_imem !== m_pc ||
          next_pc_f !== 12'((int'(m_pc) + 1) % 4096) ||
          fetch_valid !== (m_mode == 1) ||
          halted !== (m_mode == 2) ||
          fetch_count !== m_cnt ||
          (!(m_mode == 1 && halt) && flush_fd !== exp_flush)) begin
        failures++;
        $display("FAIL random i=%0d addr=%h/%h cnt=%0d/%0d v=%b h=%b f=%b/%b",
                 i, address_imem, m_pc, fetch_count, m_cnt,
                 fetch_valid, halted, flush_fd, exp_flush);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_boot_run();
    test_hazard();
    test_jump();
    test_simultaneous();
    test_wrap();
    test_halt_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
